// File: rtl/serial_deserializer_if.sv
// Serial capture bundle: serial input controls plus parallel word output.
// master drives ena/start/bit_valid/bit_in; slave returns busy/count/word.
interface serial_deserializer_if #(
  parameter int N = 8
);
  localparam int CW = $clog2(N + 1);

  logic          ena;
  logic          start;
  logic          bit_valid;
  logic          bit_in;
  logic          busy;
  logic [CW-1:0] bit_count;
  logic [N-1:0]  data_out;
  logic          data_valid;

  modport master (
    output ena, start, bit_valid, bit_in,
    input  busy, bit_count, data_out, data_valid
  );

  modport slave (
    input  ena, start, bit_valid, bit_in,
    output busy, bit_count, data_out, data_valid
  );
endinterface

// File: rtl/serial_deserializer.sv
// Serial-in/parallel-out capture: N qualified bits after start -> word + pulse.
// Ports: clk, rst (sync, active high), bus (slave side of serial_deserializer_if).
module serial_deserializer #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  serial_deserializer_if.slave bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t        state;
  state_t        state_nx;
  logic [N-1:0]  sr;
  logic [N-1:0]  sr_sh;
  logic [CW-1:0] cnt;
  logic [N-1:0]  word;
  logic          dv;
  logic          fire;
  logic          done;

  // A bit is taken only in S_SHIFT; start always outranks it.
  assign fire = bus.ena & ~bus.start & bus.bit_valid
              & (state == S_SHIFT);
  assign done = fire & (cnt == CW'(N - 1));

  assign sr_sh = MSB_FIRST ? {sr[N-2:0], bus.bit_in}
                           : {bus.bit_in, sr[N-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (bus.ena) begin
      unique case (state)
        S_IDLE:  if (bus.start) state_nx = S_SHIFT;
        S_SHIFT: begin
          if (bus.start)  state_nx = S_SHIFT;
          else if (done)  state_nx = S_IDLE;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr   <= '0;
      cnt  <= '0;
      word <= '0;
      dv   <= 1'b0;
    end else begin
      // done already carries ena, so a pulse never stretches.
      dv <= done;
      if (bus.ena) begin
        if (bus.start) begin
          sr  <= '0;
          cnt <= '0;
        end else if (fire) begin
          sr <= sr_sh;
          if (done) begin
            word <= sr_sh;
            cnt  <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      end
    end
  end

  always_comb begin
    bus.busy       = (state == S_SHIFT);
    bus.bit_count  = cnt;
    bus.data_out   = word;
    bus.data_valid = dv;
  end
endmodule

// File: tb/tb_serial_deserializer.sv
// Bench: MSB-first and LSB-first instances share one directed stimulus.
// A bit-list model predicts outputs; a negedge process compares each cycle.
module tb_serial_deserializer;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst, ena, start, bit_valid, bit_in;

  int n_chk = 0;
  int n_fail = 0;

  serial_deserializer_if #(.N(N)) if_m ();
  serial_deserializer_if #(.N(N)) if_l ();

  assign if_m.ena = ena;
  assign if_m.start = start;
  assign if_m.bit_valid = bit_valid;
  assign if_m.bit_in = bit_in;
  assign if_l.ena = ena;
  assign if_l.start = start;
  assign if_l.bit_valid = bit_valid;
  assign if_l.bit_in = bit_in;

  serial_deserializer #(.N(N), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .bus(if_m.slave)
  );
  serial_deserializer #(.N(N), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .bus(if_l.slave)
  );

  always #5 clk = ~clk;

  // Model: a list of received bits, turned into a word at completion.
  logic       m_busy = 1'b0;
  int         m_cnt = 0;
  logic       m_bits [N];
  logic [N-1:0] m_msb = '0;
  logic [N-1:0] m_lsb = '0;
  logic       m_dv = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0;
      m_cnt  = 0;
      m_msb  = '0;
      m_lsb  = '0;
      m_dv   = 1'b0;
    end else if (!ena) begin
      m_dv = 1'b0;
    end else begin
      m_dv = 1'b0;
      if (start) begin
        m_busy = 1'b1;
        m_cnt  = 0;
      end else if (m_busy && bit_valid) begin
        m_bits[m_cnt] = bit_in;
        m_cnt++;
        if (m_cnt == N) begin
          for (int i = 0; i < N; i++) begin
            m_msb[N-1-i] = m_bits[i];
            m_lsb[i]     = m_bits[i];
          end
          m_dv   = 1'b1;
          m_busy = 1'b0;
          m_cnt  = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("m.busy", 32'(if_m.busy), 32'(m_busy));
    chk("m.cnt", 32'(if_m.bit_count), 32'(m_cnt));
    chk("m.data", 32'(if_m.data_out), 32'(m_msb));
    chk("m.dv", 32'(if_m.data_valid), 32'(m_dv));
    chk("l.busy", 32'(if_l.busy), 32'(m_busy));
    chk("l.cnt", 32'(if_l.bit_count), 32'(m_cnt));
    chk("l.data", 32'(if_l.data_out), 32'(m_lsb));
    chk("l.dv", 32'(if_l.data_valid), 32'(m_dv));
  end

  task automatic cyc(input logic s, input logic bv, input logic b,
                     input logic e = 1'b1, input logic r = 1'b0);
    start = s; bit_valid = bv; bit_in = b; ena = e; rst = r;
    @(negedge clk);
  endtask

  task automatic send_word(input logic [N-1:0] w, input bit msb);
    for (int i = 0; i < N; i++)
      cyc(1'b0, 1'b1, msb ? w[N-1-i] : w[i]);
  endtask

  logic [N-1:0] a5 = 8'hA5;
  logic [N-1:0] c3 = 8'h3C;

  initial begin
    rst = 1'b1; ena = 1'b1; start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b1);
    chk("rst.busy", 32'(if_m.busy), 32'd0);
    chk("rst.cnt", 32'(if_m.bit_count), 32'd0);
    chk("rst.data", 32'(if_m.data_out), 32'h00);
    chk("rst.dv", 32'(if_m.data_valid), 32'd0);

    // stray bits without start are ignored
    cyc(1'b0, 1'b1, 1'b1);
    chk("stray.cnt", 32'(if_m.bit_count), 32'd0);

    // MSB-first A5
    cyc(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < N - 1; i++) cyc(1'b0, 1'b1, a5[N-1-i]);
    chk("a5.predv", 32'(if_m.data_valid), 32'd0);
    cyc(1'b0, 1'b1, a5[0]);
    chk("a5.data", 32'(if_m.data_out), 32'hA5);
    chk("a5.dv", 32'(if_m.data_valid), 32'd1);
    chk("a5.busy", 32'(if_m.busy), 32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("a5.dv_off", 32'(if_m.data_valid), 32'd0);

    // LSB-first 3C with gaps
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) begin
      cyc(1'b0, 1'b1, c3[i]);
      if (i < N - 1) begin
        chk("3c.cnt", 32'(if_l.bit_count), 32'(i + 1));
        cyc(1'b0, 1'b0, 1'b1);
        chk("3c.gap", 32'(if_l.bit_count), 32'(i + 1));
      end
    end
    chk("3c.data", 32'(if_l.data_out), 32'h3C);
    chk("3c.dv", 32'(if_l.data_valid), 32'd1);
    cyc(1'b0, 1'b0, 1'b0);

    // restart mid-word, then F0 MSB-first
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    chk("rs.cnt", 32'(if_m.bit_count), 32'd0);
    chk("rs.hold", 32'(if_m.data_out), 32'h3C);
    send_word(8'hF0, 1'b1);
    chk("f0.data", 32'(if_m.data_out), 32'hF0);
    chk("f0.lsb", 32'(if_l.data_out), 32'h0F);
    chk("f0.dv", 32'(if_m.data_valid), 32'd1);
    cyc(1'b0, 1'b0, 1'b0);

    // ena freeze mid-word
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'(i), 1'b1, 1'b0);
    chk("frz.cnt", 32'(if_m.bit_count), 32'd3);
    chk("frz.busy", 32'(if_m.busy), 32'd1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1);
    chk("frz.data", 32'(if_m.data_out), 32'h1F);
    chk("frz.dv", 32'(if_m.data_valid), 32'd1);
    // ena low right after completion kills the pulse
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("frz.dvoff", 32'(if_m.data_valid), 32'd0);

    // reset mid-word
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("rmw.data", 32'(if_m.data_out), 32'h00);
    chk("rmw.busy", 32'(if_m.busy), 32'd0);
    chk("rmw.cnt", 32'(if_m.bit_count), 32'd0);

    // start collides with the 8th bit
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < N - 1; i++) cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    chk("col.dv", 32'(if_m.data_valid), 32'd0);
    chk("col.busy", 32'(if_m.busy), 32'd1);
    chk("col.cnt", 32'(if_m.bit_count), 32'd0);
    chk("col.data", 32'(if_m.data_out), 32'h00);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_deserializer.md
Name: serial_deserializer

Overview:
- Serial-in, parallel-out capture stage that sits directly upstream of the team's synchronous enable/reset register.
- Shifts in N qualified serial bits after a start strobe.
- On the final bit it presents the assembled word on data_out with a one-cycle data_valid pulse. That pulse drives the downstream register's ena and data_out drives its d.
- Used for SPI/UART-style receive paths feeding register banks.

Parameters:
- N, 8, word width in bits; legal range N >= 2.
- MSB_FIRST, 1, 1 = first received bit lands in data_out[N-1]; 0 = first received bit lands in data_out[0].

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset; highest priority.
- ena  input  1  global clock enable; when 0, all state, count and outputs hold (data_valid forced 0).
- start  input  1  begin (or restart) capture of a new word.
- bit_valid  input  1  qualifies bit_in for sampling this cycle.
- bit_in  input  1  serial data bit.
- busy  output  1  1 while in S_SHIFT.
- bit_count  output  $clog2(N+1)  number of bits captured in the current word.
- data_out  output  N  last completed word; holds until the next word completes.
- data_valid  output  1  one-cycle pulse: data_out was updated on the preceding edge.

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous and active-high, rst. Priority is rst > ena > everything else.
- Reset values:
  - state = S_IDLE, busy = 0, bit_count = 0, data_valid = 0.
  - data_out = 0, internal shift register = 0.
- States: S_IDLE and S_SHIFT. busy is decoded from state (busy = 1 iff S_SHIFT).
- S_IDLE:
  - start=1 & ena=1 -> S_SHIFT; bit_count <= 0; shift register cleared.
  - bit_in/bit_valid in the start cycle are ignored.
  - bit_valid without a prior start is ignored.
- S_SHIFT, on each edge with ena=1 & bit_valid=1 & start=0:
  - MSB_FIRST=1: sr <= {sr[N-2:0], bit_in}.
  - MSB_FIRST=0: sr <= {bit_in, sr[N-1:1]}.
  - bit_count increments.
- Completion:
  - Triggered when the sampled bit is bit N (bit_count == N-1 before the edge).
  - On that same edge: data_out <= completed word (including the new bit), data_valid <= 1, bit_count <= 0, state -> S_IDLE.
  - Latency: final bit sampled at edge k; data_out/data_valid are visible in cycle k+1.
  - data_valid deasserts at edge k+1 unless another word completes (impossible back-to-back; minimum word spacing is N+1 cycles).
- Restart: start=1 in S_SHIFT (with ena=1) discards the partial word.
  - bit_count <= 0, shift register cleared, remains in S_SHIFT.
  - bit_in that cycle is ignored; data_out is unchanged; no data_valid.
- Start coinciding with completion: if start=1 on the cycle the Nth bit is valid, start wins. The word is discarded, no data_valid, and a restart occurs.
- ena=0: no sampling, no state change, bit_count and data_out hold, data_valid = 0. A pending pulse is not stretched; data_valid is registered as (completion & ena).
- rst mid-word: partial word is lost; all outputs return to reset values on the next edge.
- bit_count never exceeds N-1 while busy and is 0 in S_IDLE.
- data_out is never modified except on completion or rst.

Test Plan:
- Reset: hold rst for 2 cycles with random inputs -> busy=0, bit_count=0, data_out=8'h00, data_valid=0.
- MSB-first word (N=8, MSB_FIRST=1): start, then bits 1,0,1,0,0,1,0,1 on consecutive cycles -> data_out=8'hA5 and data_valid=1 for exactly one cycle, one cycle after the 8th bit; busy falls on that same edge.
- LSB-first word with gaps (MSB_FIRST=0): start, then send 8'h3C LSB first with bit_valid low on alternate cycles -> data_out=8'h3C; bit_count steps 0..7 only on valid cycles; a single data_valid pulse.
- Restart mid-word: start, 5 bits, start again, then 8 bits of 8'hF0 (MSB first) -> data_out=8'hF0; no data_valid after the aborted partial; previous data_out is held until completion.
- ena freeze: drop ena for 3 cycles mid-word while toggling bit_valid/bit_in -> bit_count and state frozen; those bits are not captured; the word completes correctly after ena returns.
- Reset mid-word and start/completion collision:
  - rst after 4 bits -> all outputs return to reset values.
  - start asserted together with the 8th valid bit -> no data_valid, busy=1, bit_count=0.
